// File: rtl/bp_fpga_host_pkg.sv
// bp_fpga_host_pkg: shared types for the FPGA host blocks
package bp_fpga_host_pkg;
   typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/bp_fpga_host_tx_arb_if.sv
// bp_fpga_host_tx_arb_if: requester byte streams in, one UART byte stream out
interface bp_fpga_host_tx_arb_if #(
   parameter int num_req_p = 3,
   parameter int data_width_p = 8
);
   logic [num_req_p*data_width_p-1:0] req_data_i;
   logic [num_req_p-1:0]              req_v_i;
   logic [num_req_p-1:0]              req_last_i;
   logic [num_req_p-1:0]              req_yumi_o;
   logic [data_width_p-1:0]           tx_data_o;
   logic                              tx_v_o;
   logic                              tx_ready_and_i;
   modport master (output req_data_i, req_v_i, req_last_i, tx_ready_and_i, input req_yumi_o, tx_data_o, tx_v_o);
   modport slave (input req_data_i, req_v_i, req_last_i, tx_ready_and_i, output req_yumi_o, tx_data_o, tx_v_o);
endinterface

// File: rtl/bp_fpga_host_rr_pick.sv
// bp_fpga_host_rr_pick: picks the first valid requester at or after ptr, wrapping
module bp_fpga_host_rr_pick #(
   parameter int n_p = 3,
   localparam int lg_lp = $clog2(n_p)
) (
   input  logic [n_p-1:0]   valid,
   input  logic [lg_lp-1:0] ptr,
   output logic [n_p-1:0]   grant,
   output logic [lg_lp-1:0] idx,
   output logic             any_v
);
   logic [lg_lp-1:0] j;
   always_comb begin
      grant = '0;
      idx = '0;
      j = '0;
      // scan farthest offset first so the nearest valid one wins
      for (int k = n_p-1; k >= 0; k--) begin
         j = lg_lp'((int'(ptr) + k) % n_p);
         if (valid[j]) begin
            grant = n_p'(1) << j;
            idx = j;
         end
      end
   end
   assign any_v = |valid;
endmodule

// File: rtl/bp_fpga_host_tx_arb.sv
// bp_fpga_host_tx_arb: packet-atomic round-robin arbiter muxing requester byte streams onto the host UART
module bp_fpga_host_tx_arb
   import bp_fpga_host_pkg::*;
#(
   parameter int num_req_p = 3,
   parameter int data_width_p = 8,
   parameter int gap_timeout_p = 1024,
   localparam int lg_lp = $clog2(num_req_p),
   localparam int gw_lp = $clog2(gap_timeout_p+1)
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   bp_fpga_host_tx_arb_if.slave bus,
   output logic [lg_lp-1:0] grant_id_o,
   output logic             busy_o,
   output logic             timeout_o
);
   state_e state_r, state_n;
   logic [lg_lp-1:0] rr_ptr_r, pick_idx, next_ptr;
   logic [num_req_p-1:0] pick_grant, grant_oh_r;
   logic [gw_lp-1:0] gap_r;
   logic [data_width_p-1:0] bytes [num_req_p];
   logic any_v, stream, sel_v, fire, done, gap_hit;
   for (genvar g = 0; g < num_req_p; g++) begin : g_byte
      assign bytes[g] = bus.req_data_i[g*data_width_p +: data_width_p];
   end
   bp_fpga_host_rr_pick #(.n_p(num_req_p)) pick (
      .valid(bus.req_v_i),
      .ptr(rr_ptr_r),
      .grant(pick_grant),
      .idx(pick_idx),
      .any_v(any_v)
   );
   always_comb begin
      stream = state_r == STREAM;
      sel_v = bus.req_v_i[grant_id_o];
      fire = stream & sel_v & bus.tx_ready_and_i;
      done = fire & bus.req_last_i[grant_id_o];
      gap_hit = stream & ~sel_v & (gap_r == gw_lp'(gap_timeout_p-1));
      next_ptr = (grant_id_o == lg_lp'(num_req_p-1)) ? '0 : grant_id_o + 1'b1;
      state_n = stream ? ((done | gap_hit) ? IDLE : STREAM) : (any_v ? STREAM : IDLE);
      bus.tx_data_o = bytes[grant_id_o];
      bus.tx_v_o = stream & sel_v;
      bus.req_yumi_o = fire ? grant_oh_r : '0;
      busy_o = stream;
   end
   // backpressured beats (valid but not ready) hold the gap counter
   always_ff @(posedge clk_i)
      if (!reset_n_i) begin
         state_r <= IDLE;
         rr_ptr_r <= '0;
         grant_id_o <= '0;
         grant_oh_r <= num_req_p'(1);
         gap_r <= '0;
         timeout_o <= 1'b0;
      end else begin
         state_r <= state_n;
         timeout_o <= gap_hit;
         gap_r <= (!stream || fire) ? '0 : gap_r + gw_lp'(!sel_v);
         if (!stream && any_v) begin
            grant_id_o <= pick_idx;
            grant_oh_r <= pick_grant;
         end
         if (done || gap_hit) rr_ptr_r <= next_ptr;
      end
endmodule

// File: tb/tb_bp_fpga_host_tx_arb.sv
// tb_bp_fpga_host_tx_arb: vector table plus hand sequences, tx bytes checked through a scoreboard queue
module tb_bp_fpga_host_tx_arb;
   logic clk = 1'b0;
   logic reset_n;
   logic [1:0] grant_id;
   logic busy, timeout;
   int checks = 0, errors = 0;
   logic [9:0] expq [$];
   logic [9:0] mon_e;
   typedef struct {
      logic [2:0] v, last;
      logic rdy, txv;
      logic [2:0] yumi;
      logic [1:0] g;
      logic busy;
   } vec_t;
   vec_t tbl [14];

   bp_fpga_host_tx_arb_if #(.num_req_p(3), .data_width_p(8)) bus ();
   bp_fpga_host_tx_arb #(.num_req_p(3), .data_width_p(8), .gap_timeout_p(16)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus), .grant_id_o(grant_id), .busy_o(busy), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", n, a, e);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] last, input logic rdy, input logic [23:0] d);
      bus.req_v_i = v;
      bus.req_last_i = last;
      bus.tx_ready_and_i = rdy;
      bus.req_data_i = d;
   endtask

   task automatic expect_tx(input logic [1:0] g, input logic [7:0] b);
      expq.push_back({g, b});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk)
      if (bus.tx_v_o && bus.tx_ready_and_i) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected actual %0h expected none", bus.tx_data_o);
         end else begin
            mon_e = expq.pop_front();
            chk("tx_data", 32'(bus.tx_data_o), 32'(mon_e[7:0]));
            chk("tx_grant", 32'(grant_id), 32'(mon_e[9:8]));
            chk("tx_yumi", 32'(bus.req_yumi_o), 32'(1) << mon_e[9:8]);
         end
      end else chk("yumi_idle", 32'(bus.req_yumi_o), 32'(0));

   initial begin
      tbl[0]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0};
      tbl[1]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
      tbl[2]  = '{3'b111, 3'b001, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
      tbl[3]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0};
      tbl[4]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
      tbl[5]  = '{3'b111, 3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1};
      tbl[6]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd1, 1'b0};
      tbl[7]  = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1};
      tbl[8]  = '{3'b111, 3'b100, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1};
      tbl[9]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd2, 1'b0};
      tbl[10] = '{3'b111, 3'b000, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
      tbl[11] = '{3'b111, 3'b001, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1};
      tbl[12] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0};
      tbl[13] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0};
      reset_n = 1'b0;
      drive(3'b000, 3'b000, 1'b1, 24'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_txv", 32'(bus.tx_v_o), 32'(0));
      chk("rst_grant", 32'(grant_id), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_timeout", 32'(timeout), 32'(0));
      tick;
      // round robin over 2-byte packets, all requesters valid
      for (int k = 0; k < 14; k++) begin
         drive(tbl[k].v, tbl[k].last, tbl[k].rdy, 24'hC2C1C0);
         if (tbl[k].txv) expect_tx(tbl[k].g, 8'hC0 + 8'(tbl[k].g));
         @(negedge clk);
         chk($sformatf("tbl%0d_txv", k), 32'(bus.tx_v_o), 32'(tbl[k].txv));
         chk($sformatf("tbl%0d_yumi", k), 32'(bus.req_yumi_o), 32'(tbl[k].yumi));
         chk($sformatf("tbl%0d_grant", k), 32'(grant_id), 32'(tbl[k].g));
         chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
         chk($sformatf("tbl%0d_timeout", k), 32'(timeout), 32'(0));
         tick;
      end
      // requester 1 packet stays atomic while requester 0 waits
      drive(3'b010, 3'b000, 1'b1, {8'hC2, 8'hA0, 8'h55});
      @(negedge clk);
      chk("s2_idle_busy", 32'(busy), 32'(0));
      tick;
      for (int k = 0; k < 4; k++) begin
         drive(k == 0 ? 3'b010 : 3'b011, k == 3 ? 3'b010 : 3'b000, 1'b1, {8'hC2, 8'hA0 + 8'(k), 8'h55});
         expect_tx(2'd1, 8'hA0 + 8'(k));
         @(negedge clk);
         chk("s2_txv", 32'(bus.tx_v_o), 32'(1));
         chk("s2_grant", 32'(grant_id), 32'(1));
         tick;
      end
      drive(3'b001, 3'b001, 1'b1, {8'hC2, 8'hA3, 8'h55});
      @(negedge clk);
      chk("s2_bubble", 32'(bus.tx_v_o), 32'(0));
      tick;
      expect_tx(2'd0, 8'h55);
      @(negedge clk);
      chk("s2_next_grant", 32'(grant_id), 32'(0));
      tick;
      // requester 1 stalls after one byte: gap timeout then grant moves to 2
      drive(3'b010, 3'b000, 1'b1, {8'hC2, 8'hB0, 8'hC0});
      tick;
      expect_tx(2'd1, 8'hB0);
      @(negedge clk);
      chk("s3_txv", 32'(bus.tx_v_o), 32'(1));
      tick;
      for (int i = 0; i < 16; i++) begin
         drive(3'b000, 3'b000, 1'b1, 24'hC2C1C0);
         @(negedge clk);
         chk($sformatf("s3_gap%0d_timeout", i), 32'(timeout), 32'(0));
         chk($sformatf("s3_gap%0d_busy", i), 32'(busy), 32'(1));
         tick;
      end
      drive(3'b111, 3'b000, 1'b1, 24'hC2C1C0);
      @(negedge clk);
      chk("s3_timeout_pulse", 32'(timeout), 32'(1));
      chk("s3_timeout_busy", 32'(busy), 32'(0));
      tick;
      drive(3'b100, 3'b100, 1'b1, 24'hC2C1C0);
      expect_tx(2'd2, 8'hC2);
      @(negedge clk);
      chk("s3_timeout_end", 32'(timeout), 32'(0));
      chk("s3_grant_after", 32'(grant_id), 32'(2));
      tick;
      drive(3'b000, 3'b000, 1'b1, 24'hC2C1C0);
      tick;
      // 100 cycles of backpressure mid-packet is not a gap
      drive(3'b001, 3'b000, 1'b1, {8'hC2, 8'hC1, 8'hD0});
      tick;
      expect_tx(2'd0, 8'hD0);
      tick;
      for (int i = 0; i < 100; i++) begin
         drive(3'b001, 3'b000, 1'b0, {8'hC2, 8'hC1, 8'hD1});
         @(negedge clk);
         chk("s4_bp_timeout", 32'(timeout), 32'(0));
         chk("s4_bp_txv", 32'(bus.tx_v_o), 32'(1));
         chk("s4_bp_data", 32'(bus.tx_data_o), 32'(8'hD1));
         tick;
      end
      drive(3'b001, 3'b000, 1'b1, {8'hC2, 8'hC1, 8'hD1});
      expect_tx(2'd0, 8'hD1);
      tick;
      drive(3'b001, 3'b001, 1'b1, {8'hC2, 8'hC1, 8'hD2});
      expect_tx(2'd0, 8'hD2);
      tick;
      drive(3'b000, 3'b000, 1'b1, 24'h0);
      tick;
      // reset during beat 2 of 3 drops the packet silently
      drive(3'b010, 3'b000, 1'b1, {8'hC2, 8'hE0, 8'hC0});
      tick;
      expect_tx(2'd1, 8'hE0);
      tick;
      drive(3'b010, 3'b000, 1'b1, {8'hC2, 8'hE1, 8'hC0});
      expect_tx(2'd1, 8'hE1);
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      drive(3'b000, 3'b000, 1'b1, 24'h0);
      @(negedge clk);
      chk("s5_txv", 32'(bus.tx_v_o), 32'(0));
      chk("s5_busy", 32'(busy), 32'(0));
      chk("s5_grant", 32'(grant_id), 32'(0));
      chk("s5_timeout", 32'(timeout), 32'(0));
      tick;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("s5_no_timeout", 32'(timeout), 32'(0));
         tick;
      end
      // back-to-back single-beat packets on requester 2
      for (int k = 0; k < 10; k++) begin
         drive(3'b100, 3'b100, 1'b1, {8'hF0 + 8'(k), 8'hC1, 8'hC0});
         @(negedge clk);
         chk("s6_bubble", 32'(bus.tx_v_o), 32'(0));
         tick;
         expect_tx(2'd2, 8'hF0 + 8'(k));
         @(negedge clk);
         chk("s6_txv", 32'(bus.tx_v_o), 32'(1));
         chk("s6_grant", 32'(grant_id), 32'(2));
         tick;
      end
      drive(3'b000, 3'b000, 1'b1, 24'h0);
      tick;
      chk("sb_empty", 32'(expq.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
